// File: rtl/mac_array_feeder_if.sv
// Upstream handshake bundle for mac_array_feeder: weight-row words and input vectors.
// The upstream producer uses the master modport; the feeder uses slave.
interface mac_array_feeder_if #(
    parameter int DW    = 8,
    parameter int LANES = 5
);
    logic                  w_valid;
    logic [DW*LANES-1:0]   w_data;
    logic                  w_ready;
    logic                  x_valid;
    logic [DW*LANES-1:0]   x_data;
    logic                  x_ready;

    modport master (
        output w_valid, w_data, x_valid, x_data,
        input  w_ready, x_ready
    );

    modport slave (
        input  w_valid, w_data, x_valid, x_data,
        output w_ready, x_ready
    );
endinterface

// File: rtl/mac_array_feeder.sv
// Transmit-side sequencer for a LANES x LANES systolic MAC array: loads weight rows,
// then streams input vectors with a per-lane diagonal skew and flushes the skew pipeline.
module mac_array_feeder #(
    parameter int DW    = 8,
    parameter int LANES = 5,
    parameter int MAXT  = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  start_i,
    input  logic [2:0]            n_i,
    input  logic [4:0]            t_i,
    mac_array_feeder_if.slave     bus_if,
    output logic [DW*LANES-1:0]   Weight_o,
    output logic                  enW_o,
    output logic [DW*LANES-1:0]   In_o,
    output logic                  enI_o,
    output logic [2:0]            N_o,
    output logic [4:0]            T_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int         BW     = DW * LANES;
    localparam logic [4:0] LAST_W = 5'(LANES - 1);
    localparam logic [4:0] MAX_T  = 5'(MAXT);
    localparam logic [2:0] MAX_N  = 3'(LANES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      n_q, n_d;
    logic [4:0]      t_q, t_d;
    logic [BW-1:0]   weight_q, weight_d;
    logic [BW-1:0]   in_q, in_d;
    logic            enw_q, eni_q;
    logic            w_ready_q, w_ready_d;
    logic            x_ready_q, x_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            w_hs_s, x_hs_s, adv_s, start_ok_s;
    logic [BW-1:0]   skew_in_s, skew_out_s;

    assign w_hs_s     = bus_if.w_valid & w_ready_q;
    assign x_hs_s     = bus_if.x_valid & x_ready_q;
    assign adv_s      = x_hs_s | (state_q == S_DRAIN);
    assign start_ok_s = (n_i != 3'd0) && (n_i <= MAX_N) && (t_i != 5'd0) && (t_i <= MAX_T);

    // Next-state, counter and registered-output logic of the tile sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        t_d      = t_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && start_ok_s) begin
                    n_d     = n_i;
                    t_d     = t_i;
                    cnt_d   = 5'd0;
                    state_d = S_LOAD_W;
                end else begin
                    err_d   = start_i;
                end
            end
            S_LOAD_W: begin
                if (w_hs_s && (cnt_q == LAST_W)) begin
                    cnt_d   = 5'd0;
                    state_d = S_STREAM;
                end else if (w_hs_s) begin
                    cnt_d   = cnt_q + 5'd1;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            S_STREAM: begin
                if (x_hs_s && (cnt_q == (t_q - 5'd1))) begin
                    cnt_d   = 5'd0;
                    state_d = (n_q > 3'd1) ? S_DRAIN : S_DONE;
                end else if (x_hs_s) begin
                    cnt_d   = cnt_q + 5'd1;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            S_DRAIN: begin
                // N-1 zero advances push the deepest live lane out of its delay line
                if (cnt_q == ({2'b00, n_q} - 5'd2)) begin
                    cnt_d   = 5'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_hs_s) begin
            weight_d = bus_if.w_data;
        end else begin
            weight_d = weight_q;
        end
        if (adv_s) begin
            in_d = skew_out_s;
        end else begin
            in_d = in_q;
        end
        w_ready_d = (state_d == S_LOAD_W);
        x_ready_d = (state_d == S_STREAM);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_q == S_DONE);
    end

    // Masks lanes beyond N at the pipeline entry; drain beats carry zeros in every lane.
    always_comb begin
        skew_in_s = '0;
        for (int k = 0; k < LANES; k++) begin
            if (x_hs_s && (k < int'(n_q))) begin
                skew_in_s[BW-1-DW*k -: DW] = bus_if.x_data[BW-1-DW*k -: DW];
            end else begin
                skew_in_s[BW-1-DW*k -: DW] = '0;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k == 0) begin : g_direct
            assign skew_out_s[BW-1 -: DW] = skew_in_s[BW-1 -: DW];
        end else begin : g_delay
            logic [k*DW-1:0] dl_q;

            // Lane k delay line, k entries deep; the oldest entry sits in the top slot.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    dl_q <= '0;
                end else if (adv_s) begin
                    dl_q <= (k*DW)'({dl_q, skew_in_s[BW-1-DW*k -: DW]});
                end else begin
                    dl_q <= dl_q;
                end
            end

            assign skew_out_s[BW-1-DW*k -: DW] = dl_q[k*DW-1 -: DW];
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            n_q       <= 3'd0;
            t_q       <= 5'd0;
            weight_q  <= '0;
            in_q      <= '0;
            enw_q     <= 1'b0;
            eni_q     <= 1'b0;
            w_ready_q <= 1'b0;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            t_q       <= t_d;
            weight_q  <= weight_d;
            in_q      <= in_d;
            enw_q     <= w_hs_s;
            eni_q     <= adv_s;
            w_ready_q <= w_ready_d;
            x_ready_q <= x_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus_if.w_ready = w_ready_q;
    assign bus_if.x_ready = x_ready_q;
    assign Weight_o       = weight_q;
    assign enW_o          = enw_q;
    assign In_o           = in_q;
    assign enI_o          = eni_q;
    assign N_o            = n_q;
    assign T_o            = t_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
endmodule

// File: doc/mac_array_feeder.md
Name: mac_array_feeder

Overview:
- Transmit-side sequencer for the 5x5 systolic MAC array; drives its Weight_i/enW_i and In_i/enI_i ports.
- Accepts weight rows and input vectors from upstream over valid/ready handshakes.
- Shifts the 5 weight rows into the array, then streams input vectors with diagonal skew: lane k is delayed k beats.
- Flushes the skew pipeline and signals completion of the tile.

Parameters:
- DW, 8: lane data width in bits.
- LANES, 5: number of array rows/lanes; bus width is DW*LANES.
- MAXT, 16: maximum input vectors per tile.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- start_i  in  1  tile start pulse; honoured only in IDLE.
- n_i  in  3  active rows, valid range 1..5; sampled at start.
- t_i  in  5  vectors in tile, valid range 1..MAXT; sampled at start.
- w_valid_i  in  1  weight word valid.
- w_data_i  in  40  weight row word.
- w_ready_o  out  1  weight word accepted when high with w_valid_i.
- x_valid_i  in  1  input vector valid.
- x_data_i  in  40  input vector; lane k at bits [39-8k:32-8k].
- x_ready_o  out  1  input vector accepted when high with x_valid_i.
- Weight_o  out  40  to array Weight_i.
- enW_o  out  1  to array enW_i.
- In_o  out  40  skewed lanes to array In_i.
- enI_o  out  1  to array enI_i.
- N_o  out  3  latched n.
- T_o  out  5  latched t.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (async assert, sync deassert) clears all registers, including the skew delay lines.
  - State = IDLE.
  - Weight_o, In_o, N_o, T_o = 0.
  - enW_o, enI_o, w_ready_o, x_ready_o, busy_o, done_o, err_o = 0.
- All outputs are registered. A reset mid-tile aborts the tile with no done_o.
- IDLE:
  - start_i with n_i in 1..5 and t_i in 1..MAXT: latch N_o/T_o, clear counters, go to LOAD_W.
  - start_i with an out-of-range value: err_o pulses on the next cycle, stay in IDLE, N_o/T_o unchanged.
- LOAD_W:
  - w_ready_o=1. Each handshake: Weight_o <= w_data_i and enW_o=1 in the following cycle; otherwise enW_o=0 and Weight_o holds.
  - Always exactly LANES words, regardless of N. Upstream sends the deepest row first.
  - After the 5th handshake go to STREAM. x_ready_o=0 throughout.
- STREAM:
  - x_ready_o=1 until T vectors have been accepted.
  - Each accepted beat advances the skew pipeline one step, and enI_o=1 in the next cycle.
  - Lane 0 of beat j appears on In_o the cycle after acceptance. Lane k appears on the k-th advance after that.
  - Lanes k>=N are forced to 0 at entry to the skew pipeline.
  - No beat accepted: enI_o=0 and In_o holds (the array stalls consistently).
  - After the T-th beat: go to DRAIN if N>1, else DONE.
- DRAIN:
  - Exactly N-1 consecutive advances with zeros injected into every lane; enI_o=1 on each.
  - x_ready_o=0, w_ready_o=0.
  - Then go to DONE.
- DONE:
  - done_o=1 for one cycle, then IDLE.
  - N_o/T_o hold until the next accepted start.
- Totals per tile: 5 enW_o beats and T+N-1 enI_o beats.
- Simultaneous/boundary cases:
  - start_i while busy: ignored, no err_o.
  - x_valid_i during LOAD_W: not accepted.
  - w_valid_i outside LOAD_W: not accepted.
  - t_i=MAXT: the counter must not wrap.
  - Back-to-back tiles: start_i in the DONE->IDLE cycle is ignored; it is honoured from IDLE.

Test Plan:
1. Reset mid-STREAM (N=5, T=4, after 2 beats): all outputs zero immediately. After release, a new start with N=5, T=4 gives a clean tile; In_o has no stale bytes.
2. Weight load, w_valid_i with 1-cycle gaps, words 0x0101010101..0x0505050505: Weight_o/enW_o show exactly 5 pulses in order, then x_ready_o rises.
3. N=5, T=3, vectors 0x1112131415, 0x2122232425, 0x3132333435, x_valid_i held high: enI_o high 7 consecutive cycles.
   - Advance 1: In_o = 0x1100000000.
   - Advance 3: In_o = 0x3122130000.
   - Advance 7: In_o = 0x0000000035.
   - done_o pulses one cycle after the last advance.
4. N=2, T=2, same data: lanes 2..4 always 0, one drain advance, 3 enI_o beats total.
5. N=1, T=1: no DRAIN, a single enI_o beat, then done_o.
6. start_i with n_i=0, then with t_i=0: err_o pulses each time, busy_o stays 0. start_i during LOAD_W: ignored, no err_o.
